// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding the decode stage.
// Issues sequential word-aligned fetch requests to instruction memory,
// buffers in-order responses with their PCs in a small prefetch FIFO and
// hands them to decode over a valid/ready handshake. A redirect from
// execute flushes the FIFO, restarts fetch at the new PC and marks every
// request still outstanding as stale so its response is discarded.
//
// Credit scheme: a request may only issue while count + inflight < DEPTH,
// so every response that is kept always finds a free FIFO slot.

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  logic [31:0] fetch_pc_q, fetch_pc_d;   // next address to request
  logic [31:0] rsp_pc_q,   rsp_pc_d;     // PC of the next kept response
  cnt_t        count_q,    count_d;      // FIFO occupancy
  cnt_t        inflight_q, inflight_d;   // requests accepted, not yet answered
  cnt_t        drop_q,     drop_d;       // oldest in-flight responses that are stale
  ptr_t        wr_ptr_q,   wr_ptr_d;
  ptr_t        rd_ptr_q,   rd_ptr_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];

  // --------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------
  logic [CNT_W:0] occupancy;
  logic           credit_ok;
  logic           req_fire;
  logic           rsp_beat;
  logic           rsp_stale;
  logic           push;
  logic           pop;
  logic [31:0]    redirect_pc_aligned;

  // Derive request/response/pop qualifiers and drive the outputs.
  always_comb begin
    occupancy           = {1'b0, count_q} + {1'b0, inflight_q};
    credit_ok           = occupancy < (CNT_W+1)'(DEPTH);
    redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    imem_req_valid = !redirect && credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    // A beat with nothing outstanding is a protocol violation: ignore it.
    rsp_beat  = imem_rsp_valid && (inflight_q != '0);
    rsp_stale = rsp_beat && (drop_q != '0);
    push      = rsp_beat && !rsp_stale && !redirect;

    instr_valid = (count_q != '0) && !redirect;
    pop         = instr_valid && instr_ready;

    // No bypass: decode only ever sees the registered head entry.
    instr    = instr_mem_q[rd_ptr_q];
    instr_pc = pc_mem_q[rd_ptr_q];
  end

  // Next-state logic; redirect overrides every other update.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // branches below can leave one unassigned and infer a latch.
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Any beat this cycle retires one request; everything left is stale.
      inflight_d = inflight_q - cnt_t'(rsp_beat);
      drop_d     = inflight_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
      inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_beat);
      drop_d     = drop_q - cnt_t'(rsp_stale);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which
    // entries are meaningful, which lets the array map onto plain RAM.
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: a behavioural instruction memory with
// configurable latency, plus a scoreboard of {pc, word} pairs pushed when a
// non-stale response is driven and popped when decode consumes an entry.
`timescale 1ns/1ps

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        pend_q[$];     // requests accepted by the memory model
  exp_t        exp_q[$];      // scoreboard of words decode must see, in order
  logic [31:0] issue_log[$];
  logic [31:0] pop_log[$];

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  rsp_lat = 1;
  bit  rsp_hold = 1'b0;
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_instr_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample outputs mid-cycle,
  // update the models, then advance to just after the next rising edge.
  task automatic tick();
    req_t r;
    exp_t e;
    bit   beat;
    beat           = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && !rsp_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      beat           = 1'b1;
    end
    #3;
    obs_req_valid   = imem_req_valid;
    obs_req_addr    = imem_req_addr;
    obs_instr_valid = instr_valid;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (redirect) begin
        chk("instr_valid_during_redirect", 32'(instr_valid), 32'd0);
        chk("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_with_nothing_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.data);
        end
        pop_log.push_back(instr_pc);
      end
      if (beat) begin
        r = pend_q.pop_front();
        if (!redirect && !r.stale) exp_q.push_back('{r.addr, mem_word(r.addr)});
      end
      if (redirect) begin
        exp_q.delete();
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back('{imem_req_addr, 1'b0, cyc + rsp_lat});
        issue_log.push_back(imem_req_addr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    rsp_hold       = 1'b0;
    rsp_lat        = 1;
    run(2);
    rst = 1'b0;
    issue_log.delete();
    pop_log.delete();
  endtask

  // Stop issuing and let every outstanding word reach decode.
  task automatic drain(input string tag);
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    rsp_hold       = 1'b0;
    redirect       = 1'b0;
    run(12);
    chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_no_pending"}, 32'(pend_q.size()), 32'd0);
    chk({tag, "_instr_valid_idle"}, 32'(obs_instr_valid), 32'd0);
  endtask

  initial begin
    int first_issue;
    int first_valid;

    // ---- 1: reset state and streaming with 1-cycle memory latency ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    tick();
    chk("reset_instr_valid", 32'(obs_instr_valid), 32'd0);
    chk("reset_req_valid", 32'(obs_req_valid), 32'd1);
    chk("reset_req_addr", obs_req_addr, 32'h0);
    first_issue = cyc - 1;
    first_valid = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_instr_valid) begin
        first_valid = cyc - 1;
        break;
      end
    end
    chk("first_valid_latency", 32'(first_valid - first_issue), 32'd2);
    chk("first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
    run(10);
    for (int i = 0; i < 4; i++)
      chk("seq_addr", (issue_log.size() > i) ? issue_log[i] : 32'hDEAD_BEEF, 32'(4 * i));
    drain("stream");

    // ---- 2: decode stalled, credits exhaust at DEPTH ----
    do_reset();
    imem_req_ready = 1'b1;
    run(10);
    chk("stall_issue_count", 32'(issue_log.size()), 32'd4);
    chk("stall_last_addr", (issue_log.size() > 0) ? issue_log[$] : 32'hDEAD_BEEF, 32'hC);
    chk("stall_req_valid", 32'(obs_req_valid), 32'd0);
    chk("stall_fifo_words", 32'(exp_q.size()), 32'd4);
    instr_ready = 1'b1;
    tick();
    chk("unstall_req_valid_same_cycle", 32'(obs_req_valid), 32'd0);
    chk("unstall_first_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("unstall_req_valid_next", 32'(obs_req_valid), 32'd1);
    chk("unstall_req_addr_next", obs_req_addr, 32'h10);
    drain("stall");

    // ---- 3: redirect with 2 FIFO entries and 2 in flight ----
    do_reset();
    imem_req_ready = 1'b1;
    rsp_hold       = 1'b1;
    run(6);
    rsp_hold = 1'b0;
    run(2);
    rsp_hold = 1'b1;
    chk("pre_redirect_fifo", 32'(exp_q.size()), 32'd2);
    chk("pre_redirect_inflight", 32'(pend_q.size()), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect    = 1'b0;
    rsp_hold    = 1'b0;
    instr_ready = 1'b1;
    pop_log.delete();
    run(8);
    chk("redirect_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);
    drain("redirect");

    // ---- 4: misaligned redirect target ----
    imem_req_ready = 1'b1;
    pop_log.delete();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    tick();
    chk("align_req_valid", 32'(obs_req_valid), 32'd1);
    chk("align_req_addr", obs_req_addr, 32'h100);
    run(6);
    chk("align_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);
    drain("align");

    // ---- 5: push and pop in one cycle at count=3, inflight=1 ----
    do_reset();
    imem_req_ready = 1'b1;
    rsp_hold       = 1'b1;
    run(6);
    rsp_hold = 1'b0;
    run(3);
    rsp_hold = 1'b1;
    chk("full3_fifo", 32'(exp_q.size()), 32'd3);
    rsp_hold    = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("pushpop_pop_count", 32'(pop_log.size()), 32'd1);
    chk("pushpop_req_valid_same", 32'(obs_req_valid), 32'd0);
    rsp_hold       = 1'b1;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    chk("pushpop_req_eligible", 32'(obs_req_valid), 32'd1);
    chk("pushpop_req_addr", obs_req_addr, 32'h10);
    instr_ready = 1'b1;
    run(6);
    chk("pushpop_total_pops", 32'(pop_log.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("pushpop_order", (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_BEEF, 32'(4 * i));
    drain("pushpop");

    // ---- 6: redirect coinciding with a response beat, then back-to-back ----
    do_reset();
    imem_req_ready = 1'b1;
    rsp_hold       = 1'b1;
    run(6);
    rsp_hold = 1'b0;
    run(1);
    chk("beatredir_fifo", 32'(exp_q.size()), 32'd1);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("beatredir_no_pop", 32'(pop_log.size()), 32'd0);
    chk("beatredir_drop", 32'(dut.drop_q), 32'd2);
    chk("beatredir_inflight", 32'(dut.inflight_q), 32'd2);
    redirect_pc = 32'h300;
    tick();
    chk("b2b_drop", 32'(dut.drop_q), 32'd1);
    redirect = 1'b0;
    run(8);
    chk("b2b_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h300);
    drain("b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the core's decode stage.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel; memory returns in-order responses.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Flushes on a redirect from the execute stage (taken branch/jump) and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the maximum of FIFO occupancy plus in-flight requests (power of 2, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect  input  1  execute stage requests a flush and refetch from redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  32  fetch address, word aligned
imem_rsp_valid  input  1  response data valid; responses return in request order with latency ≥1
imem_rsp_data  input  32  fetched instruction word
instr_valid  output  1  FIFO head valid toward decode
instr_ready  input  1  decode consumes the head; low means stall
instr  output  32  head instruction
instr_pc  output  32  PC of head instruction

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc and rsp_pc are set to RESET_PC.
  - FIFO count, inflight and drop are set to 0.
  - Outputs after reset: instr_valid=0, imem_req_valid=1, imem_req_addr=RESET_PC.
  - Reset mid-operation abandons everything; instruction memory shares rst, so no late responses arrive.
- Request issue:
  - imem_req_valid = !redirect && (count + inflight < DEPTH).
  - imem_req_addr = fetch_pc.
  - A request is accepted when valid && ready in the same cycle. fetch_pc then += 4 (wraps mod 2^32) and inflight += 1.
  - Memory must not depend on valid being held stable: valid may drop without a handshake, e.g. on redirect.
- Response handling:
  - A response beat with drop>0 is discarded; drop -= 1 and inflight -= 1.
  - Otherwise the word is pushed with pc=rsp_pc; rsp_pc += 4 and inflight -= 1.
  - The credit rule guarantees the FIFO is never full on a push, including a push with no pop in the same cycle.
  - imem_rsp_valid with inflight=0 is a protocol violation and is ignored; no state changes.
- Output:
  - instr_valid = (count>0) && !redirect.
  - instr and instr_pc come combinationally from the head entry.
  - A pop occurs on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged. Data passes through the FIFO with at least 1 cycle of latency; there is no bypass.
- Redirect (highest priority):
  - FIFO is emptied (count=0, pointers reset).
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2],2'b00}.
  - No request issues and no pop occurs in that cycle.
  - Any response beat in that cycle is discarded.
  - drop is set to inflight − (imem_rsp_valid ? 1 : 0) + existing-drop adjustment, i.e. every request still outstanding after this cycle is marked stale; inflight is updated to the same value.
  - Back-to-back redirects are legal; the last one wins and drop accumulates correctly.
- Widths:
  - count, inflight and drop are each log2(DEPTH)+1 bits.
  - Invariant: drop ≤ inflight and count + inflight ≤ DEPTH at all times.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency, instr_ready=1: request addresses are 0x0, 0x4, 0x8…; instr_valid is first seen 2 cycles after the first accept, with instr_pc=0x0 and the instruction word matching in order.
- instr_ready=0, memory always ready (DEPTH=4): exactly 4 requests (0x0–0xC) are accepted, then imem_req_valid=0 permanently. Raising instr_ready pops 0x0 and a new request for 0x10 issues in the following cycle.
- Redirect to 0x100 with 2 requests in flight (0x8, 0xC) and 2 FIFO entries: the FIFO empties; the next 2 responses are discarded; the first instr_pc is 0x100 with the 0x100 data; no 0x8/0xC word ever appears.
- redirect_pc=0x103: the next imem_req_addr is 0x100 and the resulting instr_pc is 0x100.
- FIFO at count=3 with inflight=1: a response and a pop in the same cycle give count=3, the order is preserved, and a new request becomes eligible.
- A redirect in the same cycle as a response beat and instr_ready=1: that beat is dropped, no pop occurs, instr_valid is 0 during the cycle, and drop equals the remaining in-flight count.
